ram_word_sequencer: RTL and testbench
=====================================

Name: ram_word_sequencer

Overview:
- Arbitrates the single 16-bit external RAM between the fetch stage and the memory stage.
- Splits every 32-bit word access into two sequential 16-bit RAM cycles: high half first, then low half.
- Returns the assembled word with a one-cycle ack pulse.
- Sits between the pipeline's fetch/memory stages and the Ram model. The memory stage has priority by default.

Parameters:
- ADDR_W, 18, byte-address width of requester addresses and of ram_addr.
- HALF_W, 16, RAM data width. The word width is 2*HALF_W.

Ports:
- clock  input  1  single system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-low reset.
- if_req  input  1  fetch read request; held high until if_ack is seen.
- if_addr  input  ADDR_W  fetch byte address.
- if_rdata  output  2*HALF_W  fetched word; valid when if_ack=1, held until the next fetch completion.
- if_ack  output  1  one-cycle completion pulse for fetch.
- mem_req  input  1  memory-stage request; held high until mem_ack is seen.
- mem_we  input  1  1=write, 0=read.
- mem_addr  input  ADDR_W  memory-stage byte address.
- mem_wdata  input  2*HALF_W  write word.
- mem_rdata  output  2*HALF_W  read word; valid when mem_ack=1, held until the next memory read completion.
- mem_ack  output  1  one-cycle completion pulse for the memory stage.
- ram_addr  output  ADDR_W  RAM halfword address.
- ram_wre  output  1  0=write cycle, 1=read/idle.
- ram_wdata  output  HALF_W  halfword to write.
- ram_rdata  input  HALF_W  halfword read from the RAM (combinational read path).
- busy  output  1  high in every state except IDLE.

Behaviour:
- States: IDLE, HI, LO, RESP. Encoding is free.
- Reset (reset=0 at a rising edge):
  - state=IDLE.
  - if_ack=0, mem_ack=0, if_rdata=0, mem_rdata=0.
  - All latched request fields are cleared to 0.
  - ram_wre is forced to 1 combinationally whenever reset=0, so no RAM write occurs during the reset cycle.
- Reset mid-operation:
  - Aborts the access; no ack is issued.
  - A write may be left half-done (high half only). This is accepted behaviour.
- IDLE:
  - Outputs: ram_wre=1, ram_addr=0, ram_wdata=0.
  - If mem_req=1: latch owner=MEM, we=mem_we, base=(mem_addr>>1) with bit0 cleared, and wdata; go to HI.
  - Else if if_req=1: latch owner=IF, we=0, base=(if_addr>>1) with bit0 cleared; go to HI.
  - Else stay in IDLE.
  - Address bits [1:0] of the byte address are ignored (word alignment is forced).
- HI:
  - Outputs: ram_addr=base, ram_wre=~we, ram_wdata=wdata[2H-1:H].
  - On read, capture ram_rdata into rbuf[2H-1:H] at the edge.
  - Go to LO.
- LO:
  - Outputs: ram_addr=base+1, computed modulo 2^ADDR_W (wraps to 0 at the top).
  - ram_wre=~we, ram_wdata=wdata[H-1:0].
  - On read, capture rbuf[H-1:0].
  - Go to RESP.
- RESP:
  - Outputs: ram_wre=1; the owner's ack is 1 for exactly this cycle.
  - The owner's rdata is updated at entry to RESP with the full word on reads; it is unchanged on writes.
  - Requests are ignored in RESP. Go to IDLE.
- Latency: request accepted in the IDLE cycle; ack 3 cycles later. One word completes every 4 cycles back-to-back.
- Handshake:
  - The requester must drop req on the edge that ends the ack cycle.
  - A req still high in the following IDLE is treated as a new access.
- Simultaneous requests: mem wins (unless ARB_FAIR_EN); the fetch request stays pending.
- Latched fields are frozen from IDLE exit until RESP. Input changes mid-access have no effect.
- The acks are mutually exclusive. if_ack is never asserted for a write.

Optional Feature:
- Macro: ARB_FAIR_EN.
- Defined:
  - A 1-bit last_owner register is added; reset value is MEM.
  - When both requests are high in IDLE, the grant goes to the requester that was not last_owner.
  - Single requests are granted as normal.
  - last_owner updates at each grant.
- Undefined: strict memory-stage priority. Fetch can starve while mem_req stays asserted.

Test Plan:
- Reset, then fetch read: RAM[0x100]=0xDEAD, RAM[0x101]=0xBEEF. Raise if_req with if_addr=0x200. Expected: ram_addr 0x100 then 0x101 with ram_wre=1; if_ack pulses in cycle 3; if_rdata=0xDEADBEEF.
- Memory write: mem_we=1, mem_addr=0x010, mem_wdata=0x12345678. Expected: ram_wre=0 with ram_addr=0x008/ram_wdata=0x1234, then 0x009/0x5678; mem_ack pulses; if_rdata unchanged.
- Simultaneous if_req and mem_req (read, mem_addr=0x020). Expected: mem served first (ram_addr 0x010, 0x011) with mem_ack at cycle 3; fetch then starts in the next IDLE with if_ack at cycle 7. With ARB_FAIR_EN and last_owner=MEM, fetch is served first.
- Wrap and alignment: if_addr=0x3FFFF. Expected: base=0x1FFFE; second cycle ram_addr=0x1FFFF; if_addr=0x203 gives the same accesses as 0x200.
- Reset asserted during LO of a write. Expected: ram_wre=1 in the reset cycle; no mem_ack; state returns to IDLE; busy=0 the next cycle.
- Back-to-back fetch with if_req held high across the ack. Expected: a second access starts in the IDLE cycle right after RESP, and a second if_ack appears 4 cycles after the first.

Source files
------------

// File: rtl/ram_word_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : ram_word_sequencer
// Purpose  : Shares one 16-bit external RAM between the fetch stage and the
//            memory stage. Each 32-bit word access becomes two RAM cycles,
//            high half first, then low half. The assembled word is returned
//            with a one-cycle ack pulse.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clock      in   system clock, rising-edge active
//   reset      in   synchronous, active-low reset
//   if_req     in   fetch read request (held until if_ack)
//   if_addr    in   fetch byte address
//   if_rdata   out  fetched word (valid with if_ack, held afterwards)
//   if_ack     out  fetch completion pulse
//   mem_req    in   memory-stage request (held until mem_ack)
//   mem_we     in   1 = write, 0 = read
//   mem_addr   in   memory-stage byte address
//   mem_wdata  in   write word
//   mem_rdata  out  read word (valid with mem_ack, held afterwards)
//   mem_ack    out  memory-stage completion pulse
//   ram_addr   out  RAM halfword address
//   ram_wre    out  0 = write cycle, 1 = read / idle
//   ram_wdata  out  halfword to write
//   ram_rdata  in   halfword from RAM (combinational read)
//   busy       out  high whenever the sequencer is not idle
// ----------------------------------------------------------------------------
// Build option:
//   ARB_FAIR_EN  when defined, simultaneous requests alternate between the
//                two requesters instead of always favouring the memory stage.
// ============================================================================
module ram_word_sequencer #(
  parameter int ADDR_W = 18,
  parameter int HALF_W = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  if_req,
  input  logic [ADDR_W-1:0]     if_addr,
  output logic [2*HALF_W-1:0]   if_rdata,
  output logic                  if_ack,
  input  logic                  mem_req,
  input  logic                  mem_we,
  input  logic [ADDR_W-1:0]     mem_addr,
  input  logic [2*HALF_W-1:0]   mem_wdata,
  output logic [2*HALF_W-1:0]   mem_rdata,
  output logic                  mem_ack,
  output logic [ADDR_W-1:0]     ram_addr,
  output logic                  ram_wre,
  output logic [HALF_W-1:0]     ram_wdata,
  input  logic [HALF_W-1:0]     ram_rdata,
  output logic                  busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HI   = 2'd1,
    S_LO   = 2'd2,
    S_RESP = 2'd3
  } state_t;

  localparam logic OWNER_IF  = 1'b0;
  localparam logic OWNER_MEM = 1'b1;
  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t                state_q;
  logic                  owner_q;
  logic                  we_q;
  logic [ADDR_W-1:0]     base_q;
  logic [2*HALF_W-1:0]   wdata_q;
  logic [HALF_W-1:0]     rbuf_hi_q;
  logic [2*HALF_W-1:0]   if_rdata_q;
  logic [2*HALF_W-1:0]   mem_rdata_q;
  logic                  if_ack_q;
  logic                  mem_ack_q;

  // Halfword base of the word: byte address >> 1 with bit 0 cleared, which
  // also discards byte-address bits [1:0] and forces word alignment.
  logic [ADDR_W-1:0]     if_base_d;
  logic [ADDR_W-1:0]     mem_base_d;
  assign if_base_d  = {1'b0, if_addr[ADDR_W-1:2], 1'b0};
  assign mem_base_d = {1'b0, mem_addr[ADDR_W-1:2], 1'b0};

  // Byte-offset bits are intentionally dropped.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{if_addr[1:0], mem_addr[1:0]};

  // Arbitration: grant_mem_d / grant_if_d are only acted upon in IDLE.
  logic grant_mem_d;
  logic grant_if_d;

`ifdef ARB_FAIR_EN
  logic last_owner_q;
  // On a collision the requester that was not served last wins.
  assign grant_mem_d = mem_req && (!if_req || (last_owner_q == OWNER_IF));
`else
  assign grant_mem_d = mem_req;
`endif
  assign grant_if_d = if_req && !grant_mem_d;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      owner_q     <= OWNER_IF;
      we_q        <= 1'b0;
      base_q      <= '0;
      wdata_q     <= '0;
      rbuf_hi_q   <= '0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
      if_ack_q    <= 1'b0;
      mem_ack_q   <= 1'b0;
`ifdef ARB_FAIR_EN
      last_owner_q <= OWNER_MEM;
`endif
    end else begin
      // Acks are single-cycle: only the LO->RESP transition raises one.
      if_ack_q  <= 1'b0;
      mem_ack_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (grant_mem_d) begin
            owner_q <= OWNER_MEM;
            we_q    <= mem_we;
            base_q  <= mem_base_d;
            wdata_q <= mem_wdata;
            state_q <= S_HI;
`ifdef ARB_FAIR_EN
            last_owner_q <= OWNER_MEM;
`endif
          end else if (grant_if_d) begin
            owner_q <= OWNER_IF;
            we_q    <= 1'b0;
            base_q  <= if_base_d;
            wdata_q <= '0;
            state_q <= S_HI;
`ifdef ARB_FAIR_EN
            last_owner_q <= OWNER_IF;
`endif
          end
        end
        S_HI: begin
          if (!we_q) begin
            rbuf_hi_q <= ram_rdata;
          end
          state_q <= S_LO;
        end
        S_LO: begin
          // The low half arrives now, so the full word is published directly
          // into the owner's read register as RESP is entered.
          if (owner_q == OWNER_MEM) begin
            mem_ack_q <= 1'b1;
            if (!we_q) begin
              mem_rdata_q <= {rbuf_hi_q, ram_rdata};
            end
          end else begin
            if_ack_q   <= 1'b1;
            if_rdata_q <= {rbuf_hi_q, ram_rdata};
          end
          state_q <= S_RESP;
        end
        S_RESP: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // RAM drive is a pure function of state and latched fields. ram_wre is
  // forced high while reset is asserted so no write lands in a reset cycle.
  always_comb begin
    ram_addr  = '0;
    ram_wre   = 1'b1;
    ram_wdata = '0;
    unique case (state_q)
      S_HI: begin
        ram_addr  = base_q;
        ram_wre   = ~we_q;
        ram_wdata = wdata_q[2*HALF_W-1:HALF_W];
      end
      S_LO: begin
        ram_addr  = base_q + ADDR_ONE;
        ram_wre   = ~we_q;
        ram_wdata = wdata_q[HALF_W-1:0];
      end
      default: begin
        ram_addr  = '0;
        ram_wre   = 1'b1;
        ram_wdata = '0;
      end
    endcase
    if (!reset) begin
      ram_wre = 1'b1;
    end
  end

  assign if_rdata  = if_rdata_q;
  assign mem_rdata = mem_rdata_q;
  assign if_ack    = if_ack_q;
  assign mem_ack   = mem_ack_q;
  assign busy      = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_ram_word_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_word_sequencer
// Purpose  : Self-checking bench for ram_word_sequencer. A behavioural RAM
//            model sits on the RAM port; a vector table drives single word
//            accesses and hand-written sequences cover arbitration,
//            back-to-back fetch and reset in the middle of a write. Expected
//            ack owner and held read words go through a scoreboard queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ram_word_sequencer;

  localparam int ADDR_W = 18;
  localparam int HALF_W = 16;
`ifdef ARB_FAIR_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif

  logic                clock;
  logic                reset;
  logic                if_req;
  logic [ADDR_W-1:0]   if_addr;
  logic [31:0]         if_rdata;
  logic                if_ack;
  logic                mem_req;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_addr;
  logic [31:0]         mem_wdata;
  logic [31:0]         mem_rdata;
  logic                mem_ack;
  logic [ADDR_W-1:0]   ram_addr;
  logic                ram_wre;
  logic [HALF_W-1:0]   ram_wdata;
  logic [HALF_W-1:0]   ram_rdata;
  logic                busy;

  ram_word_sequencer #(.ADDR_W(ADDR_W), .HALF_W(HALF_W)) dut (
    .clock     (clock),
    .reset     (reset),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_rdata  (if_rdata),
    .if_ack    (if_ack),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .ram_addr  (ram_addr),
    .ram_wre   (ram_wre),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata),
    .busy      (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // RAM model: combinational read, write on the rising edge when ram_wre=0.
  logic [HALF_W-1:0] ram_model [0:(1<<ADDR_W)-1];
  assign ram_rdata = ram_model[ram_addr];
  always @(posedge clock) begin
    if (ram_wre === 1'b0) ram_model[ram_addr] <= ram_wdata;
  end

  typedef struct {
    bit          is_mem;
    bit          we;
    logic [17:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [17:0] hi_addr;
  } vec_t;

  typedef struct {
    bit          is_mem;
    logic [31:0] exp_if;
    logic [31:0] exp_mem;
  } sb_t;

  sb_t  sb_q[$];
  vec_t vecs[10];

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] held_if;
  logic [31:0] held_mem;
  bit          last_owner_mem;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Record the expected outcome of one access at the moment it is issued.
  task automatic push_exp(input bit is_mem, input bit we, input logic [31:0] rd);
    sb_t item;
    if (!we) begin
      if (is_mem) held_mem = rd;
      else        held_if  = rd;
    end
    item.is_mem  = is_mem;
    item.exp_if  = held_if;
    item.exp_mem = held_mem;
    sb_q.push_back(item);
    last_owner_mem = is_mem;
  endtask

  // Scoreboard consumer: every ack pops one expectation.
  always @(negedge clock) begin
    if (if_ack === 1'b1 && mem_ack === 1'b1) begin
      check("ack_exclusive", 32'(if_ack & mem_ack), 32'd0);
    end
    if (if_ack === 1'b1 || mem_ack === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("unexpected_ack", 32'({if_ack, mem_ack}), 32'd0);
      end else begin
        sb_t item;
        item = sb_q.pop_front();
        check("ack_owner_mem", 32'(mem_ack), 32'(item.is_mem));
        check("if_rdata", if_rdata, item.exp_if);
        check("mem_rdata", mem_rdata, item.exp_mem);
      end
    end
  end

  // One complete word access; entered just after a rising edge with the DUT
  // idle, returns just after the edge that ends the ack cycle.
  task automatic run_vec(input vec_t v);
    push_exp(v.is_mem, v.we, v.rdata);
    if (v.is_mem) begin
      mem_req = 1'b1; mem_we = v.we; mem_addr = v.addr; mem_wdata = v.wdata;
    end else begin
      if_req = 1'b1; if_addr = v.addr;
    end
    @(negedge clock);
    check("idle_busy", 32'(busy), 32'd0);
    @(negedge clock);
    check("hi_addr", 32'(ram_addr), 32'(v.hi_addr));
    check("hi_wre", 32'(ram_wre), 32'(!v.we));
    if (v.we) check("hi_wdata", 32'(ram_wdata), 32'(v.wdata[31:16]));
    // Disturb the inputs mid-access; latched fields must not follow.
    if_addr   = ~v.addr;
    mem_addr  = ~v.addr;
    mem_wdata = ~v.wdata;
    mem_we    = ~v.we;
    @(negedge clock);
    check("lo_addr", 32'(ram_addr), 32'(v.hi_addr + 18'd1));
    check("lo_wre", 32'(ram_wre), 32'(!v.we));
    if (v.we) check("lo_wdata", 32'(ram_wdata), 32'(v.wdata[15:0]));
    @(negedge clock);
    check("ack_latency", 32'(v.is_mem ? mem_ack : if_ack), 32'd1);
    check("resp_wre", 32'(ram_wre), 32'd1);
    check("resp_busy", 32'(busy), 32'd1);
    @(posedge clock); #1;
    if_req = 1'b0; mem_req = 1'b0; mem_we = 1'b0;
  endtask

  initial begin
    bit first_mem;

    for (int i = 0; i < (1 << ADDR_W); i++) ram_model[i] = '0;
    ram_model[18'h00100] = 16'hDEAD;
    ram_model[18'h00101] = 16'hBEEF;
    ram_model[18'h1FFFE] = 16'hCAFE;
    ram_model[18'h1FFFF] = 16'hF00D;
    ram_model[18'h00010] = 16'h1111;
    ram_model[18'h00011] = 16'h2222;

    //                 mem  we   addr        wdata         rdata         hi_addr
    vecs[0] = '{1'b0, 1'b0, 18'h00200, 32'h00000000, 32'hDEADBEEF, 18'h00100};
    vecs[1] = '{1'b1, 1'b1, 18'h00010, 32'h12345678, 32'h00000000, 18'h00008};
    vecs[2] = '{1'b1, 1'b0, 18'h00010, 32'h00000000, 32'h12345678, 18'h00008};
    vecs[3] = '{1'b0, 1'b0, 18'h00203, 32'h00000000, 32'hDEADBEEF, 18'h00100};
    vecs[4] = '{1'b0, 1'b0, 18'h3FFFF, 32'h00000000, 32'hCAFEF00D, 18'h1FFFE};
    vecs[5] = '{1'b1, 1'b1, 18'h3FFFD, 32'hA5A55A5A, 32'h00000000, 18'h1FFFE};
    vecs[6] = '{1'b0, 1'b0, 18'h3FFFC, 32'h00000000, 32'hA5A55A5A, 18'h1FFFE};
    vecs[7] = '{1'b1, 1'b0, 18'h00022, 32'h00000000, 32'h11112222, 18'h00010};
    vecs[8] = '{1'b1, 1'b1, 18'h00202, 32'h0BADF00D, 32'h00000000, 18'h00100};
    vecs[9] = '{1'b0, 1'b0, 18'h00200, 32'h00000000, 32'h0BADF00D, 18'h00100};

    reset = 1'b0; if_req = 1'b0; if_addr = '0;
    mem_req = 1'b0; mem_we = 1'b0; mem_addr = '0; mem_wdata = '0;
    held_if = '0; held_mem = '0; last_owner_mem = 1'b1;

    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_wre", 32'(ram_wre), 32'd1);
    check("rst_addr", 32'(ram_addr), 32'd0);
    check("rst_acks", 32'({if_ack, mem_ack}), 32'd0);
    check("rst_if_rdata", if_rdata, 32'd0);
    check("rst_mem_rdata", mem_rdata, 32'd0);
    @(posedge clock); #1;
    reset = 1'b1;

    for (int i = 0; i < 10; i++) run_vec(vecs[i]);

    // Simultaneous requests: strict priority serves mem first; the fair
    // arbiter serves whoever did not own the previous grant.
    first_mem = FAIR ? !last_owner_mem : 1'b1;
    if (first_mem) begin
      push_exp(1'b1, 1'b0, 32'h11112222);
      push_exp(1'b0, 1'b0, 32'h0BADF00D);
    end else begin
      push_exp(1'b0, 1'b0, 32'h0BADF00D);
      push_exp(1'b1, 1'b0, 32'h11112222);
    end
    if_req = 1'b1; if_addr = 18'h00200;
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 18'h00020;
    @(negedge clock);
    @(negedge clock);
    check("sim_first_addr", 32'(ram_addr), first_mem ? 32'h10 : 32'h100);
    @(negedge clock);
    check("sim_first_lo", 32'(ram_addr), first_mem ? 32'h11 : 32'h101);
    @(negedge clock);
    check("sim_first_ack", 32'({if_ack, mem_ack}), first_mem ? 32'd1 : 32'd2);
    @(posedge clock); #1;
    if (first_mem) mem_req = 1'b0; else if_req = 1'b0;
    @(negedge clock);
    check("sim_gap_busy", 32'(busy), 32'd0);
    @(negedge clock);
    check("sim_second_addr", 32'(ram_addr), first_mem ? 32'h100 : 32'h10);
    @(negedge clock);
    @(negedge clock);
    check("sim_second_ack", 32'({if_ack, mem_ack}), first_mem ? 32'd2 : 32'd1);
    @(posedge clock); #1;
    if_req = 1'b0; mem_req = 1'b0;

    // Back-to-back fetch with if_req held across the ack.
    push_exp(1'b0, 1'b0, 32'h0BADF00D);
    push_exp(1'b0, 1'b0, 32'h0BADF00D);
    if_req = 1'b1; if_addr = 18'h00200;
    repeat (4) @(negedge clock);
    check("b2b_ack1", 32'(if_ack), 32'd1);
    @(negedge clock);
    check("b2b_gap", 32'({if_ack, busy}), 32'd0);
    @(negedge clock);
    check("b2b_hi_addr", 32'(ram_addr), 32'h100);
    @(negedge clock);
    @(negedge clock);
    check("b2b_ack2", 32'(if_ack), 32'd1);
    @(posedge clock); #1;
    if_req = 1'b0;

    // Reset during the LO cycle of a write: aborted, no ack.
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = 18'h00040; mem_wdata = 32'hFFFF0000;
    @(negedge clock);
    @(negedge clock);
    check("abort_hi_wre", 32'(ram_wre), 32'd0);
    @(posedge clock); #1;
    reset = 1'b0; mem_req = 1'b0; mem_we = 1'b0;
    @(negedge clock);
    check("abort_lo_wre", 32'(ram_wre), 32'd1);
    check("abort_lo_busy", 32'(busy), 32'd1);
    @(posedge clock); #1;
    reset = 1'b1;
    held_if = '0; held_mem = '0; last_owner_mem = 1'b1;
    @(negedge clock);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_ack", 32'(mem_ack), 32'd0);
    check("abort_if_rdata", if_rdata, 32'd0);
    check("abort_mem_rdata", mem_rdata, 32'd0);
    repeat (4) @(negedge clock);
    check("abort_still_idle", 32'({busy, if_ack, mem_ack}), 32'd0);

    check("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Absolute time limit as a safety net.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
